// File: rtl/aximm_follower_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : aximm_follower_mem_if
// Description : AXI4 memory-mapped bus bundle (AW, W, B, AR, R channels)
//               with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface aximm_follower_mem_if #(
    parameter int DWIDTH    = 128,
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4
);
    // write address channel
    logic [IDWIDTH-1:0]   awid;
    logic [ADDRWIDTH-1:0] awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;
    // write data channel
    logic [DWIDTH-1:0]    wdata;
    logic [DWIDTH/8-1:0]  wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;
    // write response channel
    logic [IDWIDTH-1:0]   bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    // read address channel
    logic [IDWIDTH-1:0]   arid;
    logic [ADDRWIDTH-1:0] araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;
    // read data channel
    logic [IDWIDTH-1:0]   rid;
    logic [DWIDTH-1:0]    rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/aximm_follower_mem.sv
`default_nettype none
// ============================================================================
// Module      : aximm_follower_mem
// Description : AXI4 memory-mapped follower backed by an internal
//               word-addressed store. Independent read and write engines,
//               ID echo, byte strobes, FIXED/INCR/WRAP bursts, SLVERR on
//               out-of-range beats or illegal bursts, per-burst done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module aximm_follower_mem #(
    parameter int DWIDTH    = 128,
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4,
    parameter int DEPTH     = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aximm_follower_mem_if.slave   s_axi,
    output logic                  wr_done,
    output logic                  rd_done
);

    localparam int c_nbytes   = DWIDTH / 8;
    localparam int c_addr_lsb = $clog2(c_nbytes);
    localparam int c_idxw     = ADDRWIDTH - c_addr_lsb;
    localparam int c_aw       = $clog2(DEPTH);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    // Next word index of a burst; size is ignored, every beat is one word.
    function automatic logic [c_idxw-1:0] f_next_idx(
        input logic [c_idxw-1:0] idx,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [c_idxw-1:0] l;
        l = c_idxw'(len);
        case (burst)
            2'd0:    f_next_idx = idx;
            2'd2:    f_next_idx = (idx & ~l) | ((idx + 1'b1) & l);
            default: f_next_idx = idx + 1'b1;
        endcase
    endfunction

    // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats.
    function automatic logic f_bad_burst(input logic [7:0] len, input logic [1:0] burst);
        f_bad_burst = (burst == 2'd3) ||
                      ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    // DEPTH is a power of two, so any set bit above the storage address is out of range.
    function automatic logic f_oor(input logic [c_idxw-1:0] idx);
        f_oor = ((idx >> c_aw) != '0);
    endfunction

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    w_state_t            r_w_state;
    w_state_t            w_w_state_nxt;
    logic [IDWIDTH-1:0]  r_w_id;
    logic [c_idxw-1:0]   r_w_idx;
    logic [7:0]          r_w_len;
    logic [1:0]          r_w_burst;
    logic                r_w_bad;
    logic                r_w_err;
    logic [IDWIDTH-1:0]  r_bid;
    logic [1:0]          r_bresp;
    logic                r_wr_done;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_w_beat_err;
    logic [c_aw-1:0]     w_w_addr;

    assign w_aw_hs      = (r_w_state == W_IDLE) && s_axi.awvalid;
    assign w_w_hs       = (r_w_state == W_DATA) && s_axi.wvalid;
    assign w_b_hs       = (r_w_state == W_RESP) && s_axi.bready;
    assign w_w_beat_err = r_w_bad || f_oor(r_w_idx);
    assign w_w_addr     = r_w_idx[c_aw-1:0];

    // Write state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_w_state <= W_IDLE;
        else        r_w_state <= w_w_state_nxt;
    end

    // Write next-state: address, data until wlast, then hold the response.
    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs)                   w_w_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && s_axi.wlast)     w_w_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs)                    w_w_state_nxt = W_IDLE;
            default:                                w_w_state_nxt = W_IDLE;
        endcase
    end

    // Write burst context, sticky error and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_id    <= '0;
            r_w_idx   <= '0;
            r_w_len   <= '0;
            r_w_burst <= '0;
            r_w_bad   <= 1'b0;
            r_w_err   <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= c_resp_okay;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            if (w_aw_hs) begin
                r_w_id    <= s_axi.awid;
                r_w_idx   <= s_axi.awaddr[ADDRWIDTH-1:c_addr_lsb];
                r_w_len   <= s_axi.awlen;
                r_w_burst <= s_axi.awburst;
                r_w_bad   <= f_bad_burst(s_axi.awlen, s_axi.awburst);
                r_w_err   <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_idx <= f_next_idx(r_w_idx, r_w_len, r_w_burst);
                if (w_w_beat_err) r_w_err <= 1'b1;
                if (s_axi.wlast) begin
                    r_bid   <= r_w_id;
                    r_bresp <= (r_w_err || w_w_beat_err) ? c_resp_slverr : c_resp_okay;
                end
            end
            if (w_b_hs) begin
                r_wr_done <= 1'b1;
                r_w_err   <= 1'b0;
            end
        end
    end

    assign s_axi.awready = (r_w_state == W_IDLE);
    assign s_axi.wready  = (r_w_state == W_DATA);
    assign s_axi.bvalid  = (r_w_state == W_RESP);
    assign s_axi.bid     = r_bid;
    assign s_axi.bresp   = r_bresp;
    assign wr_done       = r_wr_done;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    r_state_t            r_r_state;
    r_state_t            w_r_state_nxt;
    logic [c_idxw-1:0]   r_r_idx;
    logic [7:0]          r_r_len;
    logic [7:0]          r_r_cnt;
    logic [1:0]          r_r_burst;
    logic                r_r_bad;
    logic [IDWIDTH-1:0]  r_rid;
    logic [DWIDTH-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rlast;
    logic                r_rd_done;

    logic                w_ar_hs;
    logic                w_r_hs;
    logic [c_idxw-1:0]   w_ar_idx;
    logic [c_idxw-1:0]   w_r_idx_nxt;
    logic [c_idxw-1:0]   w_ld_idx;
    logic                w_ld_err;
    logic [c_aw-1:0]     w_ld_addr;
    logic [DWIDTH-1:0]   w_ld_word;

    assign w_ar_hs     = (r_r_state == R_IDLE) && s_axi.arvalid;
    assign w_r_hs      = (r_r_state == R_DATA) && s_axi.rready;
    assign w_ar_idx    = s_axi.araddr[ADDRWIDTH-1:c_addr_lsb];
    assign w_r_idx_nxt = f_next_idx(r_r_idx, r_r_len, r_r_burst);
    // The word to load is the first beat on AR, otherwise the following beat.
    assign w_ld_idx    = w_ar_hs ? w_ar_idx : w_r_idx_nxt;
    assign w_ld_err    = w_ar_hs ? (f_bad_burst(s_axi.arlen, s_axi.arburst) || f_oor(w_ar_idx))
                                 : (r_r_bad || f_oor(w_r_idx_nxt));
    assign w_ld_addr   = w_ld_idx[c_aw-1:0];

    // Read state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_r_state <= R_IDLE;
        else        r_r_state <= w_r_state_nxt;
    end

    // Read next-state: stream beats until the last one is accepted.
    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs)            w_r_state_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast)  w_r_state_nxt = R_IDLE;
            default:                         w_r_state_nxt = R_IDLE;
        endcase
    end

    // Read burst context and the registered R channel payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_r_idx   <= '0;
            r_r_len   <= '0;
            r_r_cnt   <= '0;
            r_r_burst <= '0;
            r_r_bad   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
            r_rlast   <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            if (w_ar_hs) begin
                r_rid     <= s_axi.arid;
                r_r_idx   <= w_ar_idx;
                r_r_len   <= s_axi.arlen;
                r_r_burst <= s_axi.arburst;
                r_r_bad   <= f_bad_burst(s_axi.arlen, s_axi.arburst);
                r_r_cnt   <= 8'd0;
                r_rdata   <= w_ld_err ? '0 : w_ld_word;
                r_rresp   <= w_ld_err ? c_resp_slverr : c_resp_okay;
                r_rlast   <= (s_axi.arlen == 8'd0);
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast   <= 1'b0;
                    r_rd_done <= 1'b1;
                end else begin
                    r_r_idx <= w_r_idx_nxt;
                    r_r_cnt <= r_r_cnt + 8'd1;
                    r_rdata <= w_ld_err ? '0 : w_ld_word;
                    r_rresp <= w_ld_err ? c_resp_slverr : c_resp_okay;
                    r_rlast <= ((r_r_cnt + 8'd1) == r_r_len);
                end
            end
        end
    end

    assign s_axi.arready = (r_r_state == R_IDLE);
    assign s_axi.rvalid  = (r_r_state == R_DATA);
    assign s_axi.rid     = r_rid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rlast   = r_rlast;
    assign rd_done       = r_rd_done;

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane so strobes map to lane enables.
    // A load in the same cycle as a write to that word sees the old byte.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < c_nbytes; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        // Strobed lane write; error beats never touch storage.
        always_ff @(posedge clk) begin
            if (w_w_hs && !w_w_beat_err && s_axi.wstrb[g])
                r_mem[w_w_addr] <= s_axi.wdata[g*8 +: 8];
        end

        assign w_ld_word[g*8 +: 8] = r_mem[w_ld_addr];
    end : g_lane

    // Size fields and sub-word address bits carry no meaning for this store.
    logic w_unused;
    assign w_unused = ^{s_axi.awsize, s_axi.arsize,
                        s_axi.awaddr[c_addr_lsb-1:0], s_axi.araddr[c_addr_lsb-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_aximm_follower_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_aximm_follower_mem
// Description : Directed, table-driven self-checking bench for
//               aximm_follower_mem (128-bit data, 256 words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aximm_follower_mem;

    logic clk;
    logic rst_n;
    logic wr_done;
    logic rd_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] cap_data [16];
    logic [1:0]   cap_resp [16];

    aximm_follower_mem_if #(.DWIDTH(128), .ADDRWIDTH(32), .IDWIDTH(4)) axi ();

    aximm_follower_mem #(
        .DWIDTH(128), .ADDRWIDTH(32), .IDWIDTH(4), .DEPTH(256)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_axi   (axi),
        .wr_done (wr_done),
        .rd_done (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [127:0] base, input logic [15:0] strb,
                            input int bdelay, input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd4;
        axi.awburst = burst; axi.awvalid = 1'b1;
        n = 0;
        while (!axi.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_accept", 128'(n < 50), 128'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        chk("wready_latency", 128'(axi.wready), 128'd1);
        for (int b = 0; b <= int'(len); b++) begin
            axi.wdata = base + 128'(b); axi.wstrb = strb;
            axi.wlast = (b == int'(len)); axi.wvalid = 1'b1;
            n = 0;
            while (!axi.wready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        chk("bvalid_latency", 128'(axi.bvalid), 128'd1);
        chk("bid", 128'(axi.bid), 128'(id));
        chk("bresp", 128'(axi.bresp), 128'(exp_resp));
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk("bvalid_hold", 128'({axi.bvalid, axi.bid, axi.bresp}), 128'({1'b1, id, exp_resp}));
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        chk("wr_done", 128'(wr_done), 128'd1);
        chk("bvalid_clear", 128'(axi.bvalid), 128'd0);
        @(negedge clk);
        chk("wr_done_pulse", 128'(wr_done), 128'd0);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit bp, input int abort_at);
        int n;
        int st;
        logic [127:0] hd;
        logic [2:0]   hc;
        @(negedge clk);
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd4;
        axi.arburst = burst; axi.arvalid = 1'b1;
        n = 0;
        while (!axi.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_accept", 128'(n < 50), 128'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        chk("rvalid_latency", 128'(axi.rvalid), 128'd1);
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin
                chk("rvalid_timeout", 128'd0, 128'd1);
                return;
            end
            if (b == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_rvalid", 128'(axi.rvalid), 128'd0);
                chk("rst_ready", 128'({axi.arready, axi.awready}), 128'd3);
                chk("rst_rpayload", 128'({axi.rlast, axi.rid, axi.rresp}), 128'd0);
                chk("rst_rdata", axi.rdata, 128'd0);
                return;
            end
            if (bp) begin
                hd = axi.rdata; hc = {axi.rresp, axi.rlast};
                st = int'($urandom_range(0, 3));
                for (int s = 0; s < st; s++) begin
                    @(negedge clk);
                    chk("r_stable_data", axi.rdata, hd);
                    chk("r_stable_ctl", 128'({axi.rvalid, axi.rresp, axi.rlast}), 128'({1'b1, hc}));
                end
            end
            cap_data[b] = axi.rdata;
            cap_resp[b] = axi.rresp;
            chk("rid", 128'(axi.rid), 128'(id));
            chk("rlast", 128'(axi.rlast), 128'(b == int'(len)));
            axi.rready = 1'b1;
            @(negedge clk);
            axi.rready = 1'b0;
        end
        chk("rd_done", 128'(rd_done), 128'd1);
        chk("rvalid_clear", 128'(axi.rvalid), 128'd0);
        @(negedge clk);
        chk("rd_done_pulse", 128'(rd_done), 128'd0);
    endtask

    typedef struct {
        bit           wr;
        logic [3:0]   id;
        logic [31:0]  addr;
        logic [1:0]   burst;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
        logic [1:0]   resp;
        logic [127:0] rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // single-beat vectors: word n lives at byte address n*16
        vecs[0]  = '{1'b1, 4'h1, 32'h0A0,  2'd1, {128{1'b1}}, 16'hFFFF, 2'b00, 128'h0};
        vecs[1]  = '{1'b1, 4'h2, 32'h0A0,  2'd1, 128'h1111111111111111_2222222222222222, 16'h00FF, 2'b00, 128'h0};
        vecs[2]  = '{1'b0, 4'h3, 32'h0A0,  2'd1, 128'h0, 16'h0, 2'b00, 128'hFFFFFFFFFFFFFFFF_2222222222222222};
        vecs[3]  = '{1'b1, 4'h4, 32'h12C0, 2'd1, 128'h5555, 16'hFFFF, 2'b10, 128'h0};
        vecs[4]  = '{1'b0, 4'h5, 32'h12C0, 2'd1, 128'h0, 16'h0, 2'b10, 128'h0};
        vecs[5]  = '{1'b1, 4'h6, 32'h0B0,  2'd1, 128'hCAFE, 16'hFFFF, 2'b00, 128'h0};
        vecs[6]  = '{1'b1, 4'h7, 32'h0B0,  2'd3, 128'hDEAD, 16'hFFFF, 2'b10, 128'h0};
        vecs[7]  = '{1'b0, 4'h8, 32'h0B0,  2'd0, 128'h0, 16'h0, 2'b00, 128'hCAFE};
        vecs[8]  = '{1'b0, 4'h9, 32'h0A0,  2'd2, 128'h0, 16'h0, 2'b10, 128'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'h0A8,  2'd0, 128'h3, 16'h0001, 2'b00, 128'h0};
        vecs[10] = '{1'b0, 4'h0, 32'h0A0,  2'd1, 128'h0, 16'h0, 2'b00, 128'hFFFFFFFFFFFFFFFF_2222222222222203};

        rst_n = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_ready", 128'({axi.awready, axi.arready}), 128'd3);
        chk("reset_valids", 128'({axi.wready, axi.bvalid, axi.rvalid, axi.rlast, wr_done, rd_done}), 128'd0);
        chk("reset_ids", 128'({axi.bid, axi.bresp, axi.rid, axi.rresp}), 128'd0);
        chk("reset_rdata", axi.rdata, 128'd0);
        rst_n = 1'b1;

        // table of single-beat writes and reads
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                wr_burst(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].burst, vecs[i].wdata, vecs[i].wstrb, 0, vecs[i].resp);
            end else begin
                rd_burst(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].burst, 1'b0, -1);
                chk($sformatf("vec%0d_rresp", i), 128'(cap_resp[0]), 128'(vecs[i].resp));
                chk($sformatf("vec%0d_rdata", i), cap_data[0], vecs[i].rdata);
            end
        end

        // INCR write of 1..4 to words 0..3, then INCR readback
        wr_burst(4'h3, 32'h0, 8'd3, 2'd1, 128'd1, 16'hFFFF, 0, 2'b00);
        rd_burst(4'h7, 32'h0, 8'd3, 2'd1, 1'b0, -1);
        for (int b = 0; b < 4; b++) begin
            chk("incr_rdata", cap_data[b], 128'(b + 1));
            chk("incr_rresp", 128'(cap_resp[b]), 128'd0);
        end

        // WRAP: words 4..7 hold 0x40..0x43; wrap of 4 from word 6 -> 6,7,4,5
        wr_burst(4'h1, 32'h40, 8'd3, 2'd1, 128'h40, 16'hFFFF, 0, 2'b00);
        rd_burst(4'h2, 32'h60, 8'd3, 2'd2, 1'b0, -1);
        chk("wrap_b0", cap_data[0], 128'h42);
        chk("wrap_b1", cap_data[1], 128'h43);
        chk("wrap_b2", cap_data[2], 128'h40);
        chk("wrap_b3", cap_data[3], 128'h41);
        rd_burst(4'h2, 32'h60, 8'd2, 2'd2, 1'b0, -1);
        for (int b = 0; b < 3; b++) begin
            chk("wrap_len2_rresp", 128'(cap_resp[b]), 128'd2);
            chk("wrap_len2_rdata", cap_data[b], 128'd0);
        end

        // Burst crossing the top of storage: words 254,255 valid, 256,257 out of range
        wr_burst(4'h4, 32'hFE0, 8'd3, 2'd1, 128'h500, 16'hFFFF, 0, 2'b10);
        rd_burst(4'h6, 32'hFE0, 8'd3, 2'd1, 1'b0, -1);
        chk("top_rresp0", 128'(cap_resp[0]), 128'd0);
        chk("top_rresp1", 128'(cap_resp[1]), 128'd0);
        chk("top_rresp2", 128'(cap_resp[2]), 128'd2);
        chk("top_rresp3", 128'(cap_resp[3]), 128'd2);
        chk("top_rdata0", cap_data[0], 128'h500);
        chk("top_rdata1", cap_data[1], 128'h501);
        chk("top_rdata3", cap_data[3], 128'h0);

        // Concurrent AW/AR, random R backpressure, B held 5 cycles
        fork
            wr_burst(4'hA, 32'h140, 8'd1, 2'd1, 128'hAA00, 16'hFFFF, 5, 2'b00);
            rd_burst(4'h5, 32'h0, 8'd3, 2'd1, 1'b1, -1);
        join
        for (int b = 0; b < 4; b++) chk("conc_rdata", cap_data[b], 128'(b + 1));
        rd_burst(4'h5, 32'h140, 8'd1, 2'd1, 1'b1, -1);
        chk("conc_wr0", cap_data[0], 128'hAA00);
        chk("conc_wr1", cap_data[1], 128'hAA01);

        // Reset during beat 2 of an 8-beat read, then a normal burst
        rd_burst(4'h9, 32'h0, 8'd7, 2'd1, 1'b0, 2);
        rd_burst(4'hC, 32'h40, 8'd0, 2'd1, 1'b0, -1);
        chk("post_rst_rdata", cap_data[0], 128'h40);
        chk("post_rst_rresp", 128'(cap_resp[0]), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aximm_follower_mem.md
Name: aximm_follower_mem

Overview:
- Parametrised AXI4 memory-mapped follower with its own internal word-addressed storage array.
- Sits behind the AXI4 follower-side adapter as the end-point of system-level read/write traffic.
- Adds independent concurrent read/write engines, ID echo, byte strobes, FIXED/INCR/WRAP bursts, out-of-range SLVERR, and per-burst completion pulses.

Parameters:
DWIDTH, 128, data bus width in bits; multiple of 8, power of two.
ADDRWIDTH, 32, AXI byte address width.
IDWIDTH, 4, AXI ID width.
DEPTH, 256, storage words of DWIDTH bits; power of two.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
awid/awaddr/awlen/awsize/awburst  in  IDWIDTH/ADDRWIDTH/8/3/2  write address
awvalid  in  1 ; awready  out  1
wdata  in  DWIDTH ; wstrb  in  DWIDTH/8 ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
bid  out  IDWIDTH ; bresp  out  2 ; bvalid  out  1 ; bready  in  1
arid/araddr/arlen/arsize/arburst  in  IDWIDTH/ADDRWIDTH/8/3/2  read address
arvalid  in  1 ; arready  out  1
rid  out  IDWIDTH ; rdata  out  DWIDTH ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1
wr_done  out  1  one-cycle pulse on B handshake
rd_done  out  1  one-cycle pulse on last R handshake

Behaviour:
- Reset (rst_n=0 at posedge clk): awready=1, arready=1; wready, bvalid, rvalid, rlast, wr_done, rd_done=0; bid, bresp, rid, rresp, rdata=0.
- Storage contents are not reset.
- Word index: idx = addr >> log2(DWIDTH/8).
- Each beat advances one word regardless of size; awsize/arsize are ignored.
- Burst next index:
  - FIXED(0): unchanged.
  - INCR(1): idx+1.
  - WRAP(2): (idx & ~len) | ((idx+1) & len).
- WRAP with len not in {1,3,7,15}, and burst type 3 (reserved), are errors for the whole burst.
- A beat is out of range if idx >= DEPTH; no wrap-around at the top of storage.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid: capture id/addr/len/burst; awready=0, wready=1 next cycle.
  - W_DATA: on each wvalid&&wready, write byte lane i of mem[idx] only where wstrb[i]=1, then advance idx.
  - Error beats (out of range or bad burst) suppress the write and set a sticky error flag.
  - On wlast handshake: wready=0, bvalid=1, bid=captured awid, bresp=2'b10 if the error flag is set else 2'b00.
  - wlast is honoured even if the beat count differs from awlen+1; the burst terminates on wlast.
  - W_RESP: hold bvalid/bid/bresp stable until bready. On handshake: bvalid=0, wr_done=1 for one cycle, awready=1 next cycle, error flag cleared.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid: capture fields; beat counter=0; arready=0.
  - Next cycle: rvalid=1, rdata=mem[idx] (registered), rid=arid.
  - rresp per beat: 2'b10 with rdata=0 if the beat is in error, else 2'b00.
  - rlast=1 when beat counter==arlen.
  - R_DATA: rdata/rresp/rlast held stable while rvalid && !rready.
  - On handshake: advance idx and counter, load the next beat's rdata the following cycle; no bubble, rvalid stays 1.
  - On last handshake: rvalid=0, rlast=0, rd_done=1 for one cycle, arready=1 next cycle.
- Latency:
  - AR handshake to first rvalid: 1 cycle.
  - AW handshake to wready: 1 cycle.
  - wlast handshake to bvalid: 1 cycle.
- Read and write engines are fully independent and may be active in the same cycle.
- Same-word read/write collision: a registered rdata already presented is unaffected. A read load in the same cycle as a write to that word returns the old contents.
- awvalid and arvalid asserted together: both are accepted in the same cycle.
- Beat counter is 8 bits; arlen=255 yields 256 beats without overflow misbehaviour.
- Reset mid-burst: both FSMs return to IDLE with reset output values; the in-flight burst is abandoned with no response.

Test Plan:
- INCR write awaddr=0x0, awlen=3, wdata=1..4, wstrb all ones; then INCR read same -> bresp=0, bid=awid, rdata 1,2,3,4, rlast on 4th beat, rd_done pulse once.
- Write wstrb=16'h00FF over a word holding all-F -> readback upper 8 bytes 0xFF..., lower 8 bytes new data.
- WRAP read araddr word 6, arlen=3 -> beats from words 6,7,4,5; WRAP arlen=2 -> rresp=2'b10 on all beats, rdata=0.
- Read araddr word DEPTH-2, arlen=3, INCR -> rresp 0,0,2,2. Same-range write -> bresp=2, and words DEPTH-2..DEPTH-1 are written.
- Simultaneous awvalid/arvalid with rready toggled randomly and bready delayed 5 cycles -> data stable under backpressure, bvalid held 5 cycles, IDs echoed (awid=0xA, arid=0x5).
- Assert rst_n=0 mid read burst (beat 2 of 8) -> next cycle rvalid=0, arready=1. A new burst then completes normally.
